banner_cmd_loader: RTL
======================

Name: banner_cmd_loader

Overview:
Command front-end that turns a received UART byte stream into control of the banner scroll register. Collects ASCII decimal digits into an N-digit BCD word and commits it with a one-cycle write strobe. Decodes single-letter commands into one-cycle direction, start and pause strobes. Sits between the UART receiver's byte/valid output and the scroll register's data_in/write/set_left/set_right/start/pause inputs.

Parameters:
W, 4, bits per digit; each digit nibble is zero-extended to W.
N, 6, digits per banner word.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low (0 = reset asserted).
rx_data  in  8  received byte.
rx_valid  in  1  one-cycle strobe; rx_data is valid on this cycle.
data_out  out  W*N  last committed banner word, digit 0 in bits [W-1:0].
write  out  1  one-cycle commit strobe.
set_left  out  1  one-cycle strobe.
set_right  out  1  one-cycle strobe.
start  out  1  one-cycle strobe.
pause  out  1  one-cycle strobe.
err  out  1  one-cycle strobe on a rejected byte or a rejected commit.
digit_count  out  $clog2(N+1)  digits currently staged (0..N).

Behaviour:
- Reset (reset=0, async): data_out=0, staging=0, digit_count=0, all strobes 0, state=COLLECT.
- Every output is registered. Response appears on the clock edge after the edge that samples rx_valid=1. No backpressure; each cycle with rx_valid=1 is one byte.
- States: COLLECT, OVERFLOW.
- Digit '0'..'9' (0x30-0x39):
  - COLLECT with count<N: staging <= {staging[W*N-W-1:0], rx_data[3:0] zero-extended}; count+1.
  - COLLECT with count==N: byte dropped, err=1, go to OVERFLOW.
  - OVERFLOW: byte dropped, err=1.
- Commit byte CR (0x0D) or LF (0x0A):
  - COLLECT with count>0: data_out <= staging, write=1, staging and count cleared.
  - Fewer than N digits are right-aligned with zero high digits.
  - COLLECT with count==0: ignored, no strobe. CR LF back-to-back produces exactly one write.
  - OVERFLOW: no write, err=1, staging and count cleared, go to COLLECT.
- ESC (0x1B): staging and count cleared, go to COLLECT, no strobe.
- Command letters, case-insensitive:
  - 'L' -> set_left; 'R' -> set_right; 'S' -> start; 'P' -> pause.
  - Accepted in either state. Staging, count and state are unchanged.
- Any other byte: err=1, staging unchanged, state unchanged.
- At most one strobe is high per cycle. All strobes return to 0 the cycle after they fire unless a new byte arrives.
- data_out holds its value between commits.
- Reset mid-word discards staged digits; data_out returns to 0.

Decomposition:
- Shared package/header (guarded include): ASCII constants CH_0, CH_9, CH_CR, CH_LF, CH_ESC, CH_L, CH_R, CH_S, CH_P (upper and lower case); state encodings COLLECT/OVERFLOW; byte-class encoding DIGIT/COMMIT/CLEAR/CMD_L/CMD_R/CMD_S/CMD_P/OTHER.
- One sub-module: ascii_byte_classify. Combinational; maps rx_data to a byte class plus the digit nibble. The loader FSM instantiates it.

Test Plan:
- Bytes "123456\r" -> one write with data_out=24'h123456, digit_count returns to 0, err never high.
- Bytes "42\n" -> write with data_out=24'h000042. Then "\r" alone -> no write, data_out stays 24'h000042.
- Bytes "1234567\r" -> err on '7' and on '\r', no write, data_out unchanged. Then "9\r" -> data_out=24'h000009.
- Bytes 'l','R','s','p' on consecutive cycles -> set_left, set_right, start, pause each high exactly one cycle, in order, one cycle after each byte. Staged digits are unaffected: "12" + 'L' + "3\r" -> 24'h000123.
- Bytes "98" + ESC + "7\r" -> data_out=24'h000007. Byte 'x' -> err=1 for one cycle, no other strobe.
- Bytes "55", then reset pulled low asynchronously mid-cycle -> data_out=0 and digit_count=0 immediately. After release, "\r" -> no write.

Source files
------------

// File: rtl/banner_cmd_loader_pkg.sv
// Shared constants and encodings for the banner command loader.
package banner_cmd_loader_pkg;

    // ASCII bytes recognised by the loader
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_ESC  = 8'h1B;
    localparam logic [7:0] CH_L_UC = 8'h4C;
    localparam logic [7:0] CH_L_LC = 8'h6C;
    localparam logic [7:0] CH_R_UC = 8'h52;
    localparam logic [7:0] CH_R_LC = 8'h72;
    localparam logic [7:0] CH_S_UC = 8'h53;
    localparam logic [7:0] CH_S_LC = 8'h73;
    localparam logic [7:0] CH_P_UC = 8'h50;
    localparam logic [7:0] CH_P_LC = 8'h70;

    // Loader states
    typedef enum logic [0:0] {
        COLLECT  = 1'b0,
        OVERFLOW = 1'b1
    } state_t;

    // Byte classes produced by the classifier
    typedef enum logic [2:0] {
        DIGIT  = 3'd0,
        COMMIT = 3'd1,
        CLEAR  = 3'd2,
        CMD_L  = 3'd3,
        CMD_R  = 3'd4,
        CMD_S  = 3'd5,
        CMD_P  = 3'd6,
        OTHER  = 3'd7
    } byte_class_t;

endpackage

// File: rtl/banner_cmd_loader_ascii_byte_classify.sv
// Combinational classifier: maps a received byte to its command class and
// extracts the low nibble for digit bytes.
module ascii_byte_classify
    import banner_cmd_loader_pkg::*;
(
    input  logic [7:0]  i_rx_data,
    output byte_class_t o_class,
    output logic [3:0]  o_nibble
);

    // Decode the byte; anything not listed falls through to OTHER
    always_comb begin
        o_class  = OTHER;
        o_nibble = i_rx_data[3:0];
        if ((i_rx_data >= CH_0) && (i_rx_data <= CH_9)) begin
            o_class = DIGIT;
        end else begin
            case (i_rx_data)
                CH_CR, CH_LF:     o_class = COMMIT;
                CH_ESC:           o_class = CLEAR;
                CH_L_UC, CH_L_LC: o_class = CMD_L;
                CH_R_UC, CH_R_LC: o_class = CMD_R;
                CH_S_UC, CH_S_LC: o_class = CMD_S;
                CH_P_UC, CH_P_LC: o_class = CMD_P;
                default:          o_class = OTHER;
            endcase
        end
    end

endmodule

// File: rtl/banner_cmd_loader.sv
// Turns a UART byte stream into banner scroll-register control: decimal
// digits are staged into a BCD word and committed by CR/LF, letters become
// one-cycle direction/start/pause strobes.
//
// state    | meaning
// ---------+----------------------------------------------------------
// COLLECT  | accepting digits into the staging word
// OVERFLOW | too many digits seen; word is poisoned until CR/LF or ESC
module banner_cmd_loader
    import banner_cmd_loader_pkg::*;
#(
    parameter int W = 4,
    parameter int N = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic [W*N-1:0]             data_out,
    output logic                       write,
    output logic                       set_left,
    output logic                       set_right,
    output logic                       start,
    output logic                       pause,
    output logic                       err,
    output logic [$clog2(N+1)-1:0]     digit_count
);

    localparam int CW = $clog2(N+1);

    byte_class_t    w_class;
    logic [3:0]     w_nibble;
    logic [W-1:0]   w_digit;

    state_t         r_state,   w_state_nxt;
    logic [W*N-1:0] r_staging, w_staging_nxt;
    logic [CW-1:0]  r_count,   w_count_nxt;
    logic [W*N-1:0] r_data,    w_data_nxt;
    logic           r_write,   w_write_nxt;
    logic           r_left,    w_left_nxt;
    logic           r_right,   w_right_nxt;
    logic           r_start,   w_start_nxt;
    logic           r_pause,   w_pause_nxt;
    logic           r_err,     w_err_nxt;

    ascii_byte_classify u_classify (
        .i_rx_data (rx_data),
        .o_class   (w_class),
        .o_nibble  (w_nibble)
    );

    assign w_digit = W'(w_nibble);

    // Register all state and every output so the scroll register sees clean strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= COLLECT;
            r_staging <= '0;
            r_count   <= '0;
            r_data    <= '0;
            r_write   <= 1'b0;
            r_left    <= 1'b0;
            r_right   <= 1'b0;
            r_start   <= 1'b0;
            r_pause   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_staging <= w_staging_nxt;
            r_count   <= w_count_nxt;
            r_data    <= w_data_nxt;
            r_write   <= w_write_nxt;
            r_left    <= w_left_nxt;
            r_right   <= w_right_nxt;
            r_start   <= w_start_nxt;
            r_pause   <= w_pause_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Next-state and strobe decode for one received byte
    always_comb begin
        w_state_nxt   = r_state;
        w_staging_nxt = r_staging;
        w_count_nxt   = r_count;
        w_data_nxt    = r_data;
        w_write_nxt   = 1'b0;
        w_left_nxt    = 1'b0;
        w_right_nxt   = 1'b0;
        w_start_nxt   = 1'b0;
        w_pause_nxt   = 1'b0;
        w_err_nxt     = 1'b0;

        if (rx_valid) begin
            case (w_class)
                DIGIT: begin
                    if ((r_state == COLLECT) && (r_count < CW'(N))) begin
                        // Newest digit enters at the bottom, so short words end up right-aligned
                        w_staging_nxt = {r_staging[W*(N-1)-1:0], w_digit};
                        w_count_nxt   = r_count + 1'b1;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = OVERFLOW;
                    end
                end
                COMMIT: begin
                    if (r_state == OVERFLOW) begin
                        // A poisoned word is rejected and discarded rather than truncated
                        w_err_nxt     = 1'b1;
                        w_staging_nxt = '0;
                        w_count_nxt   = '0;
                        w_state_nxt   = COLLECT;
                    end else if (r_count != '0) begin
                        w_data_nxt    = r_staging;
                        w_write_nxt   = 1'b1;
                        w_staging_nxt = '0;
                        w_count_nxt   = '0;
                    end
                    // Empty commit (e.g. the LF of a CR LF pair) is silently ignored
                end
                CLEAR: begin
                    w_staging_nxt = '0;
                    w_count_nxt   = '0;
                    w_state_nxt   = COLLECT;
                end
                CMD_L:   w_left_nxt  = 1'b1;
                CMD_R:   w_right_nxt = 1'b1;
                CMD_S:   w_start_nxt = 1'b1;
                CMD_P:   w_pause_nxt = 1'b1;
                default: w_err_nxt   = 1'b1;
            endcase
        end
    end

    assign data_out    = r_data;
    assign write       = r_write;
    assign set_left    = r_left;
    assign set_right   = r_right;
    assign start       = r_start;
    assign pause       = r_pause;
    assign err         = r_err;
    assign digit_count = r_count;

endmodule
